uart_rx_frame_ctrl: RTL and testbench

- Sequences the 8N1 UART receiver and assembles its byte stream into checked command frames.
- Frame format: SOF byte, LEN byte, LEN payload bytes, then an XOR checksum byte.
- Drives the receiver's rx_en, buffers the payload, and holds each good frame until the consumer acknowledges it.
- Sits between the UART receiver and the command decoder.

---
 rtl/uart_rx_frame_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_uart_rx_frame_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_frame_ctrl
// Brief    : Turns the 8N1 receiver byte stream (SOF, LEN, payload, XOR
//            checksum) into checked frames held until the consumer acks.
//            Macro FRAME_TIMEOUT_EN enables the inter-byte timeout.
// Revision : 1.0  initial release
// ============================================================================
module uart_rx_frame_ctrl #(
    parameter logic [7:0] SOF_BYTE       = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         ADDR_W         = 4,
    parameter int         TIMEOUT_CYCLES = 208340
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ctrl_en,
    input  logic [7:0]        rx_data,
    input  logic              rx_done,
    input  logic              rx_busy,
    output logic              rx_en,
    output logic              frame_valid,
    output logic [7:0]        frame_len,
    input  logic              frame_ack,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              err_len,
    output logic              err_chk,
    output logic              err_timeout
);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_LEN     = 3'd1;
    localparam logic [2:0] c_ST_PAYLOAD = 3'd2;
    localparam logic [2:0] c_ST_CHK     = 3'd3;
    localparam logic [2:0] c_ST_HOLD    = 3'd4;

    localparam int              c_aw1       = ADDR_W + 1;
    localparam int              c_depth     = 1 << ADDR_W;
    localparam logic [7:0]      c_max_len8  = 8'(MAX_LEN);
    localparam logic [ADDR_W:0] c_max_addr  = c_aw1'(MAX_LEN);

    logic [2:0] r_state;
    logic       r_done_prev;
    logic       r_rx_en;
    logic       r_frame_valid;
    logic [7:0] r_frame_len;
    logic [7:0] r_len;
    logic [7:0] r_chk;
    logic [7:0] r_idx;
    logic       r_err_len;
    logic       r_err_chk;
    logic [7:0] r_buf [0:c_depth-1];

    logic w_byte;
    logic w_active;
    logic w_expire;
    logic w_pay_wr;
    logic w_unused;

    // One byte per rising edge of the rx_done level
    assign w_byte   = rx_done && !r_done_prev;
    assign w_active = (r_state == c_ST_LEN) || (r_state == c_ST_PAYLOAD) ||
                      (r_state == c_ST_CHK);
    assign w_pay_wr = (r_state == c_ST_PAYLOAD) && ctrl_en && w_byte;
    assign w_unused = rx_busy;

`ifdef FRAME_TIMEOUT_EN
    localparam int                c_to_w    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT_CYCLES - 1);

    logic [c_to_w-1:0] r_to_cnt;
    logic              r_err_timeout;

    // A byte edge in the expiry cycle takes precedence over the timeout
    assign w_expire = w_active && ctrl_en && !w_byte && (r_to_cnt == c_to_last);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_to_cnt      <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_err_timeout <= w_expire;
            if (!w_active || !ctrl_en || w_byte || w_expire) begin
                r_to_cnt <= '0;
            end else begin
                r_to_cnt <= r_to_cnt + c_to_w'(1);
            end
        end
    end

    assign err_timeout = r_err_timeout;
`else
    logic w_unused_timeout;

    assign w_expire         = 1'b0;
    assign err_timeout      = 1'b0;
    assign w_unused_timeout = w_active ^ (TIMEOUT_CYCLES > 0);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= c_ST_IDLE;
            r_done_prev   <= 1'b1;
            r_rx_en       <= 1'b0;
            r_frame_valid <= 1'b0;
            r_frame_len   <= 8'h00;
            r_len         <= 8'h00;
            r_chk         <= 8'h00;
            r_idx         <= 8'h00;
            r_err_len     <= 1'b0;
            r_err_chk     <= 1'b0;
        end else begin
            r_done_prev <= rx_done;
            r_rx_en     <= ctrl_en && (r_state != c_ST_HOLD);
            r_err_len   <= 1'b0;
            r_err_chk   <= 1'b0;

            case (r_state)
                c_ST_IDLE: begin
                    if (ctrl_en && w_byte && (rx_data == SOF_BYTE)) begin
                        r_state <= c_ST_LEN;
                    end
                end

                c_ST_LEN: begin
                    if (!ctrl_en) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_byte) begin
                        if ((rx_data == 8'h00) || (rx_data > c_max_len8)) begin
                            r_err_len <= 1'b1;
                            r_state   <= c_ST_IDLE;
                        end else begin
                            r_len   <= rx_data;
                            r_chk   <= rx_data;
                            r_idx   <= 8'h00;
                            r_state <= c_ST_PAYLOAD;
                        end
                    end else if (w_expire) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                c_ST_PAYLOAD: begin
                    if (!ctrl_en) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_byte) begin
                        r_chk <= r_chk ^ rx_data;
                        r_idx <= r_idx + 8'd1;
                        if ((r_idx + 8'd1) == r_len) begin
                            r_state <= c_ST_CHK;
                        end
                    end else if (w_expire) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                c_ST_CHK: begin
                    if (!ctrl_en) begin
                        r_state <= c_ST_IDLE;
                    end else if (w_byte) begin
                        if (rx_data == r_chk) begin
                            r_frame_valid <= 1'b1;
                            r_frame_len   <= r_len;
                            r_state       <= c_ST_HOLD;
                        end else begin
                            r_err_chk <= 1'b1;
                            r_state   <= c_ST_IDLE;
                        end
                    end else if (w_expire) begin
                        r_state <= c_ST_IDLE;
                    end
                end

                c_ST_HOLD: begin
                    // Bytes arriving here, even alongside the ack, are dropped
                    if (frame_ack) begin
                        r_frame_valid <= 1'b0;
                        r_state       <= c_ST_IDLE;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_pay_wr) begin
            r_buf[r_idx[ADDR_W-1:0]] <= rx_data;
        end
    end

    assign rd_data     = ({1'b0, rd_addr} >= c_max_addr) ? 8'h00 : r_buf[rd_addr];
    assign rx_en       = r_rx_en;
    assign frame_valid = r_frame_valid;
    assign frame_len   = r_frame_len;
    assign err_len     = r_err_len;
    assign err_chk     = r_err_chk;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_frame_ctrl.sv
`default_nettype none
// Testbench for uart_rx_frame_ctrl: directed vector table, hand-written
// corner sequences, and randomized frames against a frame-level model.
module tb_uart_rx_frame_ctrl;

    localparam int         MAX_LEN = 16;
    localparam int         ADDR_W  = 4;
    localparam int         TO      = 50;
    localparam logic [7:0] SOF     = 8'hA5;
    localparam int K_NONE = 0, K_GOOD = 1, K_CHK = 2, K_LEN = 3;

    logic              clk = 1'b0;
    logic              rst, ctrl_en, rx_done, rx_busy, frame_ack;
    logic [7:0]        rx_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              rx_en, frame_valid, err_len, err_chk, err_timeout;
    logic [7:0]        frame_len, rd_data;

    uart_rx_frame_ctrl #(
        .SOF_BYTE(SOF), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst), .ctrl_en(ctrl_en), .rx_data(rx_data),
        .rx_done(rx_done), .rx_busy(rx_busy), .rx_en(rx_en),
        .frame_valid(frame_valid), .frame_len(frame_len), .frame_ack(frame_ack),
        .rd_addr(rd_addr), .rd_data(rd_data), .err_len(err_len),
        .err_chk(err_chk), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor: counts error pulses, flags overlap or multi-cycle pulses
    int   n_len = 0, n_chk = 0, n_to = 0, mon_bad = 0, to_cyc = 0;
    logic p_len = 1'b0, p_chk = 1'b0, p_to = 1'b0;
    always @(negedge clk) begin
        if (err_len)     n_len  <= n_len + 1;
        if (err_chk)     n_chk  <= n_chk + 1;
        if (err_timeout) begin
            n_to   <= n_to + 1;
            to_cyc <= cyc;
        end
        if (((int'(err_len) + int'(err_chk) + int'(err_timeout)) > 1) ||
            (err_len && p_len) || (err_chk && p_chk) || (err_timeout && p_to))
            mon_bad <= mon_bad + 1;
        p_len <= err_len;
        p_chk <= err_chk;
        p_to  <= err_timeout;
    end

    int errors = 0, checks = 0;
    int b_len, b_chk, b_to, last_edge, w;

    typedef struct {
        int          n;
        logic [63:0] b;
        int          kind;
        int          len;
        logic [31:0] pl;
    } vec_t;
    vec_t vt [0:6];

    logic [7:0] s[$];
    logic [7:0] pq[$];
    logic [7:0] epl[$];
    int         ek, el, k, L, nstray;
    logic [7:0] x, bt;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic snap;
        b_len = n_len;
        b_chk = n_chk;
        b_to  = n_to;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int hi, lo;
        hi = $urandom_range(1, 3);
        lo = $urandom_range(1, 3);
        rx_data = b;
        rx_done = 1'b1;
        rx_busy = 1'b0;
        tick;
        last_edge = cyc;
        for (int i = 1; i < hi; i++) tick;
        rx_done = 1'b0;
        rx_busy = 1'b1;
        for (int i = 0; i < lo; i++) tick;
        rx_busy = 1'b0;
    endtask

    task automatic send_seq(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i]);
    endtask

    task automatic verify(input string tag, input int kind, input int len, input logic [7:0] p[$]);
        chk({tag, " err_len"}, n_len - b_len, 32'(kind == K_LEN));
        chk({tag, " err_chk"}, n_chk - b_chk, 32'(kind == K_CHK));
        chk({tag, " err_timeout"}, n_to - b_to, 0);
        chk({tag, " frame_valid"}, frame_valid, 32'(kind == K_GOOD));
        if (kind == K_GOOD) begin
            chk({tag, " frame_len"}, frame_len, len);
            chk({tag, " rx_en in hold"}, rx_en, 0);
            for (int i = 0; i < len; i++) begin
                rd_addr = ADDR_W'(i);
                #1;
                chk({tag, " rd_data"}, rd_data, p[i]);
            end
            frame_ack = 1'b1;
            tick;
            frame_ack = 1'b0;
            chk({tag, " valid after ack"}, frame_valid, 0);
            chk({tag, " len after ack"}, frame_len, len);
            tick;
            chk({tag, " rx_en after ack"}, rx_en, 1);
        end
    endtask

    // Frame-level reference: skip to SOF, judge LEN, XOR-check the rest
    function automatic void model(input logic [7:0] q[$], output int kind,
                                  output int len, output logic [7:0] p[$]);
        int         i;
        logic [7:0] cs;
        kind = K_NONE;
        len  = 0;
        p.delete();
        i = 0;
        while (i < q.size() && q[i] != SOF) i++;
        if (i + 1 >= q.size()) return;
        len = int'(q[i+1]);
        if (len == 0 || len > MAX_LEN) begin
            kind = K_LEN;
            len  = 0;
            return;
        end
        cs = q[i+1];
        for (int j = 0; j < len; j++) begin
            p.push_back(q[i+2+j]);
            cs = cs ^ q[i+2+j];
        end
        kind = (q[i+2+len] == cs) ? K_GOOD : K_CHK;
    endfunction

    task automatic good_tail;
        pq.delete();
        pq.push_back(SOF); pq.push_back(8'h01); pq.push_back(8'h44); pq.push_back(8'h45);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        vt[0] = '{6, 64'hA5_03_11_22_33_03_00_00, K_GOOD, 3, 32'h11_22_33_00};
        vt[1] = '{5, 64'hA5_02_10_20_00_00_00_00, K_CHK,  0, 32'h0};
        vt[2] = '{5, 64'hA5_02_10_20_32_00_00_00, K_GOOD, 2, 32'h10_20_00_00};
        vt[3] = '{2, 64'hA5_00_00_00_00_00_00_00, K_LEN,  0, 32'h0};
        vt[4] = '{2, 64'hA5_11_00_00_00_00_00_00, K_LEN,  0, 32'h0};
        vt[5] = '{2, 64'h55_A4_00_00_00_00_00_00, K_NONE, 0, 32'h0};
        vt[6] = '{6, 64'h55_A4_A5_01_7E_7F_00_00, K_GOOD, 1, 32'h7E_00_00_00};

        rst = 1'b1; ctrl_en = 1'b1; rx_done = 1'b0; rx_busy = 1'b0;
        rx_data = 8'h00; frame_ack = 1'b0; rd_addr = '0;
        tick; tick;
        chk("reset rx_en", rx_en, 0);
        chk("reset frame_valid", frame_valid, 0);
        chk("reset frame_len", frame_len, 0);
        chk("reset errs", {err_len, err_chk, err_timeout}, 0);
        rst = 1'b0;
        tick; tick;
        chk("rx_en after reset", rx_en, 1);

        for (int v = 0; v < 7; v++) begin
            s.delete();
            pq.delete();
            for (int i = 0; i < vt[v].n; i++) s.push_back(vt[v].b[63-8*i -: 8]);
            for (int i = 0; i < vt[v].len; i++) pq.push_back(vt[v].pl[31-8*i -: 8]);
            snap;
            send_seq(s);
            verify($sformatf("vec%0d", v), vt[v].kind, vt[v].len, pq);
        end

        // Exact one-cycle latency from the checksum edge
        snap;
        send_byte(SOF); send_byte(8'h03); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        rx_data = 8'h03;
        rx_done = 1'b1;
        chk("valid before chk edge", frame_valid, 0);
        tick;
        chk("valid 1 cycle after chk edge", frame_valid, 1);
        rx_done = 1'b0;
        tick; tick;
        pq.delete(); pq.push_back(8'h11); pq.push_back(8'h22); pq.push_back(8'h33);
        verify("latency", K_GOOD, 3, pq);

        // Held-frame protection
        snap;
        pq.delete();
        pq.push_back(SOF); pq.push_back(8'h02); pq.push_back(8'h10); pq.push_back(8'h20); pq.push_back(8'h32);
        send_seq(pq);
        chk("hold valid", frame_valid, 1);
        send_byte(8'h99);
        chk("hold after stray", frame_valid, 1);
        rd_addr = 0; #1; chk("hold buf0", rd_data, 8'h10);
        rd_addr = 1; #1; chk("hold buf1", rd_data, 8'h20);
        rx_data = SOF; rx_done = 1'b1; frame_ack = 1'b1;
        tick;
        frame_ack = 1'b0;
        tick;
        rx_done = 1'b0;
        tick;
        chk("hold released", frame_valid, 0);
        chk("hold no errs", (n_len - b_len) + (n_chk - b_chk) + (n_to - b_to), 0);
        snap; good_tail; send_seq(pq);
        pq.delete(); pq.push_back(8'h44);
        verify("after hold", K_GOOD, 1, pq);

        // Inter-byte timeout
        snap;
        send_byte(SOF); send_byte(8'h02); send_byte(8'h10);
`ifdef FRAME_TIMEOUT_EN
        w = 0;
        while (n_to == b_to && w < 3 * TO) begin
            tick;
            w++;
        end
        chk("timeout pulse count", n_to - b_to, 1);
        chk("timeout delay", to_cyc - last_edge, TO);
`else
        repeat (3 * TO) tick;
        chk("no timeout pulse", n_to - b_to, 0);
        ctrl_en = 1'b0; tick; ctrl_en = 1'b1; tick;
`endif
        chk("timeout other errs", (n_len - b_len) + (n_chk - b_chk), 0);
        chk("timeout frame_valid", frame_valid, 0);
        snap; good_tail; send_seq(pq);
        pq.delete(); pq.push_back(8'h44);
        verify("after timeout", K_GOOD, 1, pq);

        // ctrl_en abort mid-frame, then bytes ignored while disabled in IDLE
        snap;
        send_byte(SOF); send_byte(8'h03); send_byte(8'h11);
        ctrl_en = 1'b0; tick; tick; ctrl_en = 1'b1; tick;
        send_byte(8'h22); send_byte(8'h33); send_byte(8'h03);
        pq.delete();
        verify("ctrl abort", K_NONE, 0, pq);
        snap;
        ctrl_en = 1'b0; send_byte(SOF); ctrl_en = 1'b1; tick;
        send_byte(8'h01); send_byte(8'h44); send_byte(8'h45);
        verify("ctrl idle ignore", K_NONE, 0, pq);

        // Randomized frames against the model
        for (int it = 0; it < 40; it++) begin
            s.delete();
            k = (it == 0) ? 0 : $urandom_range(0, 3);
            if (k <= 1) begin
                L = (it == 0) ? MAX_LEN : $urandom_range(1, MAX_LEN);
                s.push_back(SOF); s.push_back(8'(L));
                x = 8'(L);
                for (int i = 0; i < L; i++) begin
                    bt = 8'($urandom);
                    s.push_back(bt);
                    x = x ^ bt;
                end
                if (k == 1) x = x ^ 8'($urandom_range(1, 255));
                s.push_back(x);
            end else if (k == 2) begin
                s.push_back(SOF);
                s.push_back(($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                nstray = $urandom_range(1, 3);
                for (int i = 0; i < nstray; i++) begin
                    bt = 8'($urandom);
                    if (bt == SOF) bt = 8'h5A;
                    s.push_back(bt);
                end
            end
            snap;
            send_seq(s);
            model(s, ek, el, epl);
            verify($sformatf("rand%0d", it), ek, el, epl);
        end

        // Reset mid-payload, then rx_done held high across reset release
        send_byte(SOF); send_byte(8'h03); send_byte(8'h11);
        rst = 1'b1;
        tick;
        chk("rst mid frame_len", frame_len, 0);
        chk("rst mid frame_valid", frame_valid, 0);
        chk("rst mid rx_en", rx_en, 0);
        chk("rst mid errs", {err_len, err_chk, err_timeout}, 0);
        rx_data = SOF; rx_done = 1'b1;
        tick;
        rst = 1'b0;
        tick; tick;
        rx_done = 1'b0;
        tick;
        chk("rx_en after release", rx_en, 1);
        snap;
        send_byte(8'h01); send_byte(8'h44); send_byte(8'h45);
        pq.delete();
        verify("rx_done across reset", K_NONE, 0, pq);

        chk("pulse exclusivity/width", mon_bad, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
